// File: rtl/clk_div_pkg.sv
// Shared defaults, reset-divisor helper and per-channel flag type for the clk_div_bank slice.
package clk_div_pkg;

    localparam int NUM_CH_DEF = 4;
    localparam int DIV_W_DEF  = 8;

    typedef struct packed {
        logic out;
        logic tick;
        logic pend_v;
    } chan_flags_t;

    // Channel ch powers up dividing by 2^(ch+1), saturated to the widest divisor the register holds.
    function automatic int unsigned rst_div(input int unsigned ch, input int unsigned w);
        int unsigned max_v;
        int unsigned v;
        if (w >= 32) max_v = 32'hffff_ffff;
        else         max_v = (32'd1 << w) - 32'd1;
        if (ch >= 32) v = 32'hffff_ffff;
        else          v = (32'd1 << ch) - 32'd1;
        return (v < max_v) ? v : max_v;
    endfunction

endpackage

// File: rtl/clk_div_bank_if.sv
// Divisor-write handshake between a configuration master and clk_div_bank.
interface clk_div_bank_if #(
    parameter int CH_W  = 2,
    parameter int DIV_W = 8
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_div;

    modport master (output cfg_valid, output cfg_ch, output cfg_div, input  cfg_ready);
    modport slave  (input  cfg_valid, input  cfg_ch, input  cfg_div, output cfg_ready);
endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/pending divisor and registered 50% output with rise tick.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int               DIV_W   = 8,
    parameter logic [DIV_W-1:0] RST_DIV = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             wr_en,
    input  logic [DIV_W-1:0] wr_div,
    output logic             clk_out,
    output logic             tick,
    output logic             pend_v
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] pend_div_q, pend_div_d;
    chan_flags_t      flags_q, flags_d;
    logic             wrap;

    assign wrap = (cnt_q == div_q);

    always_comb begin
        cnt_d        = cnt_q;
        div_d        = div_q;
        pend_div_d   = pend_div_q;
        flags_d      = flags_q;
        flags_d.tick = 1'b0;
        if (!en) begin
            cnt_d       = '0;
            flags_d.out = 1'b0;
            // A stopped channel has no period to protect, so updates land at once.
            if (flags_q.pend_v) begin
                div_d          = pend_div_q;
                flags_d.pend_v = 1'b0;
            end else if (wr_en) begin
                div_d = wr_div;
            end
        end else begin
            if (wrap) begin
                cnt_d        = '0;
                flags_d.out  = ~flags_q.out;
                flags_d.tick = ~flags_q.out;
                if (flags_q.out && flags_q.pend_v) begin
                    div_d          = pend_div_q;
                    flags_d.pend_v = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
            if (wr_en) begin
                pend_div_d     = wr_div;
                flags_d.pend_v = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            div_q      <= RST_DIV;
            pend_div_q <= '0;
            flags_q    <= '0;
        end else begin
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_div_q <= pend_div_d;
            flags_q    <= flags_d;
        end
    end

    assign clk_out = flags_q.out;
    assign tick    = flags_q.tick;
    assign pend_v  = flags_q.pend_v;

endmodule

// File: rtl/clk_div_bank.sv
// Multi-channel programmable clock-divider bank with cfg decode and optional AND monitor.
// Define CLK_DIV_BANK_AND_EN to build the masked AND combiner; otherwise and_out is tied low.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int DIV_W  = DIV_W_DEF,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] ch_en,
    clk_div_bank_if.slave     cfg,
    input  logic [NUM_CH-1:0] and_mask,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic              and_out
);

    logic [NUM_CH-1:0] pend_v;
    logic [NUM_CH-1:0] wr_en;
    logic              ready;

    // Writes to channels that do not exist see ready=1 and are silently dropped.
    always_comb begin
        ready = 1'b1;
        wr_en = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg.cfg_ch == CH_W'(i)) begin
                ready = ~pend_v[i];
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            wr_en[i] = cfg.cfg_valid & ready & (cfg.cfg_ch == CH_W'(i));
        end
    end

    assign cfg.cfg_ready = ready;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        clk_div_chan #(
            .DIV_W   (DIV_W),
            .RST_DIV (DIV_W'(rst_div(g, DIV_W)))
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (ch_en[g]),
            .wr_en   (wr_en[g]),
            .wr_div  (cfg.cfg_div),
            .clk_out (clk_out[g]),
            .tick    (tick[g]),
            .pend_v  (pend_v[g])
        );
    end

`ifdef CLK_DIV_BANK_AND_EN
    logic and_q, and_d;

    always_comb begin
        and_d = 1'b0;
        if (|and_mask) begin
            and_d = &(clk_out | ~and_mask);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            and_q <= 1'b0;
        end else begin
            and_q <= and_d;
        end
    end

    assign and_out = and_q;
`else
    logic unused_and_mask;
    assign unused_and_mask = ^and_mask;
    assign and_out         = 1'b0;
`endif

endmodule
